// File: rtl/dac_spi_tx.sv
// Shifts one latched pair of 12-bit DAC codes into an MCP4922-style dual DAC:
// frame A, gap, frame B, gap, then a single LDAC_n pulse so both outputs update together.
module dac_spi_tx #(
  parameter int CLK_DIV  = 2,
  parameter bit BUF_BIT  = 1'b0,
  parameter bit GA_N_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sample_valid,
  input  logic [11:0] u_dac_a,
  input  logic [11:0] u_dac_b,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_sdi,
  output logic        dac_ldac_n
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FRAME_A = 3'd1,
    S_GAP_A   = 3'd2,
    S_FRAME_B = 3'd3,
    S_GAP_B   = 3'd4,
    S_LDAC    = 3'd5
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [8:0] GAP_M1 = 9'(2 * CLK_DIV - 1);

  function automatic logic [15:0] frame_word(input logic ab, input logic [11:0] code);
    return {ab, BUF_BIT, GA_N_BIT, 1'b1, code};
  endfunction

  state_t      r_state;
  logic [15:0] r_word_a;
  logic [15:0] r_word_b;
  logic [7:0]  r_div;
  logic [4:0]  r_half;
  logic [8:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;
  logic        r_cs_n;
  logic        r_sck;
  logic        r_sdi;
  logic        r_ldac_n;

  logic [15:0] w_word;
  logic [3:0]  w_bit_idx;
  logic        w_next_sdi;

  // r_half[4:1] is the bit just clocked out; the falling edge presents the next one.
  assign w_word     = (r_state == S_FRAME_B) ? r_word_b : r_word_a;
  assign w_bit_idx  = 4'd14 - r_half[4:1];
  assign w_next_sdi = w_word[w_bit_idx];

  // Transfer sequencer with all pin values registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_word_a  <= 16'h0000;
      r_word_b  <= 16'h0000;
      r_div     <= 8'd0;
      r_half    <= 5'd0;
      r_cnt     <= 9'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_cs_n    <= 1'b1;
      r_sck     <= 1'b0;
      r_sdi     <= 1'b0;
      r_ldac_n  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (sample_valid && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            r_word_a <= frame_word(1'b0, u_dac_a);
            r_word_b <= frame_word(1'b1, u_dac_b);
            r_cs_n   <= 1'b0;
            r_sdi    <= 1'b0;
            r_busy   <= 1'b1;
            r_div    <= 8'd0;
            r_half   <= 5'd0;
            r_state  <= S_FRAME_A;
          end
        end
        S_FRAME_A, S_FRAME_B: begin
          if (r_div == DIV_M1) begin
            r_div <= 8'd0;
            if (r_half == 5'd31) begin
              // sck falls here; cs_n is held low one more cycle so it never moves with sck high
              r_sck   <= 1'b0;
              r_sdi   <= 1'b0;
              r_cnt   <= 9'd0;
              r_state <= (r_state == S_FRAME_A) ? S_GAP_A : S_GAP_B;
            end else begin
              r_half <= r_half + 5'd1;
              r_sck  <= ~r_sck;
              if (r_sck) begin
                r_sdi <= w_next_sdi;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_GAP_A, S_GAP_B: begin
          if (r_cnt == GAP_M1) begin
            r_cnt <= 9'd0;
            if (r_state == S_GAP_A) begin
              r_cs_n  <= 1'b0;
              r_sdi   <= r_word_b[15];
              r_div   <= 8'd0;
              r_half  <= 5'd0;
              r_state <= S_FRAME_B;
            end else begin
              r_cs_n   <= 1'b1;
              r_ldac_n <= 1'b0;
              r_state  <= S_LDAC;
            end
          end else begin
            r_cs_n <= 1'b1;
            r_cnt  <= r_cnt + 9'd1;
          end
        end
        S_LDAC: begin
          if (r_cnt == GAP_M1) begin
            r_ldac_n <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_cs_n   <= 1'b1;
          r_sck    <= 1'b0;
          r_sdi    <= 1'b0;
          r_ldac_n <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign dac_cs_n   = r_cs_n;
  assign dac_sck    = r_sck;
  assign dac_sdi    = r_sdi;
  assign dac_ldac_n = r_ldac_n;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Drives three dac_spi_tx instances (CLK_DIV 1, 2, 5) from shared stimulus and
// checks captured SPI words, SCK timing, busy/done/LDAC timing and overrun/reset behaviour.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] u_dac_a = 12'h000;
  logic [11:0] u_dac_b = 12'h000;
  logic        mon_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    logic busy, done, overrun, cs_n, sck, sdi, ldac_n;
    logic [6:0] pins;
    assign pins = {cs_n, sck, sdi, ldac_n, busy, done, overrun};

    dac_spi_tx #(.CLK_DIV(D), .BUF_BIT(1'b0), .GA_N_BIT(1'b1)) dut (
      .clk(clk), .resetn(resetn), .sample_valid(sample_valid),
      .u_dac_a(u_dac_a), .u_dac_b(u_dac_b),
      .busy(busy), .done(done), .overrun(overrun),
      .dac_cs_n(cs_n), .dac_sck(sck), .dac_sdi(sdi), .dac_ldac_n(ldac_n)
    );

    logic p_cs = 1'b1, p_sck = 1'b0, p_sdi = 1'b0, p_ldac = 1'b1, p_busy = 1'b0;
    logic [15:0] sh = 16'h0000;
    logic [15:0] words [8];
    int rises [8];
    int busy_lens [8];
    int ldac_lens [8];
    int nw = 0, nb = 0, nl = 0, nbits = 0, busy_run = 0, ldac_run = 0, high_run = 0;
    int cyc = 0, last_rise = 0, have_rise = 0;
    int hmin = 1000, hmax = 0, pmin = 1000, pmax = 0, viol = 0, ndone = 0;

    // Per-instance pin monitor, sampled mid-cycle after the negative edge.
    always begin
      @(negedge clk);
      #1;
      if (mon_clr) begin
        nw = 0; nb = 0; nl = 0; nbits = 0; busy_run = 0; ldac_run = 0; high_run = 0;
        have_rise = 0; hmin = 1000; hmax = 0; pmin = 1000; pmax = 0; viol = 0; ndone = 0;
        sh = 16'h0000;
      end else begin
        cyc++;
        if (cs_n != p_cs && p_sck) viol++;
        if (sck != p_sck && cs_n && p_cs) viol++;
        if (sdi != p_sdi && sck) viol++;
        if (done && busy) viol++;
        if (sck && !p_sck) begin
          sh = {sh[14:0], sdi};
          nbits++;
          if (have_rise != 0) begin
            if (cyc - last_rise < pmin) pmin = cyc - last_rise;
            if (cyc - last_rise > pmax) pmax = cyc - last_rise;
          end
          last_rise = cyc;
          have_rise = 1;
        end
        if (sck) high_run++;
        else if (p_sck) begin
          if (high_run < hmin) hmin = high_run;
          if (high_run > hmax) hmax = high_run;
          high_run = 0;
        end
        if (cs_n && !p_cs) begin
          if (nw < 8) begin
            words[nw] = sh;
            rises[nw] = nbits;
          end
          nw++;
          nbits = 0;
          have_rise = 0;
        end
        if (busy) busy_run++;
        else if (p_busy) begin
          if (nb < 8) busy_lens[nb] = busy_run;
          nb++;
          busy_run = 0;
        end
        if (!ldac_n) ldac_run++;
        else if (!p_ldac) begin
          if (nl < 8) ldac_lens[nl] = ldac_run;
          nl++;
          ldac_run = 0;
        end
        if (done) ndone++;
      end
      p_cs = cs_n; p_sck = sck; p_sdi = sdi; p_ldac = ldac_n; p_busy = busy;
    end
  end

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] wa;
    logic [15:0] wb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic accept(input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    u_dac_a = a;
    u_dac_b = b;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic chk_xfer(input string tag, input int d, input logic [15:0] ewa, input logic [15:0] ewb,
                          input int nw, input logic [15:0] w0, input logic [15:0] w1,
                          input int r0, input int r1, input int nb, input int bl,
                          input int nl, input int ll, input int hmin, input int hmax,
                          input int pmin, input int pmax, input int viol, input int ndone);
    chk({tag, "_nframes"}, nw, 2);
    chk({tag, "_word_a"}, int'(w0), int'(ewa));
    chk({tag, "_word_b"}, int'(w1), int'(ewb));
    chk({tag, "_rises_a"}, r0, 16);
    chk({tag, "_rises_b"}, r1, 16);
    chk({tag, "_nbusy"}, nb, 1);
    chk({tag, "_busy_len"}, bl, 70 * d);
    chk({tag, "_nldac"}, nl, 1);
    chk({tag, "_ldac_len"}, ll, 2 * d);
    chk({tag, "_sck_high_min"}, hmin, d);
    chk({tag, "_sck_high_max"}, hmax, d);
    chk({tag, "_sck_per_min"}, pmin, 2 * d);
    chk({tag, "_sck_per_max"}, pmax, 2 * d);
    chk({tag, "_protocol"}, viol, 0);
    chk({tag, "_ndone"}, ndone, 1);
  endtask

  initial begin
    vec_t vecs [4];
    int first_busy, last_busy, done_at, done_busy, ldac_start, last_cs;
    int sdi_first_a, cs_first_a, sdi_first_b, cs_gap_end;

    vecs[0] = '{a: 12'h123, b: 12'hABC, wa: 16'h3123, wb: 16'hBABC};
    vecs[1] = '{a: 12'h000, b: 12'hFFF, wa: 16'h3000, wb: 16'hBFFF};
    vecs[2] = '{a: 12'hFFF, b: 12'h000, wa: 16'h3FFF, wb: 16'hB000};
    vecs[3] = '{a: 12'h5A5, b: 12'hA5A, wa: 16'h35A5, wb: 16'hBA5A};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pins_d1", int'(u[0].pins), int'(7'b1001000));
    chk("rst_pins_d2", int'(u[1].pins), int'(7'b1001000));
    chk("rst_pins_d5", int'(u[2].pins), int'(7'b1001000));
    resetn = 1'b1;
    clr_mon();

    // Cycle-exact timing of one CLK_DIV=2 transfer
    first_busy = -1; last_busy = -1; done_at = -1; done_busy = -1; ldac_start = -1; last_cs = -1;
    sdi_first_a = -1; cs_first_a = -1; sdi_first_b = -1; cs_gap_end = -1;
    accept(12'h123, 12'hABC);
    for (int n = 1; n <= 150; n++) begin
      if (u[1].busy) begin
        if (first_busy < 0) first_busy = n;
        last_busy = n;
      end
      if (u[1].done) begin
        done_at = n;
        done_busy = int'(u[1].busy);
      end
      if (!u[1].ldac_n && ldac_start < 0) ldac_start = n;
      if (!u[1].cs_n) last_cs = n;
      if (n == 1) begin
        sdi_first_a = int'(u[1].sdi);
        cs_first_a = int'(u[1].cs_n);
      end
      if (n == 68) cs_gap_end = int'(u[1].cs_n);
      if (n == 69) sdi_first_b = int'(u[1].sdi);
      @(negedge clk);
    end
    chk("t_first_busy", first_busy, 1);
    chk("t_last_busy", last_busy, 140);
    chk("t_done_cycle", done_at, 141);
    chk("t_done_busy", done_busy, 0);
    chk("t_ldac_start", ldac_start, 137);
    chk("t_ldac_after_cs", int'(ldac_start > last_cs), 1);
    chk("t_cs_first_a", cs_first_a, 0);
    chk("t_sdi_first_a", sdi_first_a, 0);
    chk("t_cs_gap_end", cs_gap_end, 1);
    chk("t_sdi_first_b", sdi_first_b, 1);
    repeat (250) @(negedge clk);
    chk_xfer("t_d2", 2, 16'h3123, 16'hBABC, u[1].nw, u[1].words[0], u[1].words[1],
             u[1].rises[0], u[1].rises[1], u[1].nb, u[1].busy_lens[0], u[1].nl,
             u[1].ldac_lens[0], u[1].hmin, u[1].hmax, u[1].pmin, u[1].pmax, u[1].viol, u[1].ndone);

    // Valid held high: back-to-back transfers and sticky overrun
    clr_mon();
    @(negedge clk);
    u_dac_a = 12'h111;
    u_dac_b = 12'h222;
    sample_valid = 1'b1;
    @(negedge clk);
    chk("b2b_overrun_c1", int'(u[1].overrun), 0);
    @(negedge clk);
    chk("b2b_overrun_c2", int'(u[1].overrun), 1);
    repeat (288) @(negedge clk);
    sample_valid = 1'b0;
    repeat (500) @(negedge clk);
    chk("b2b_ndone_d1", u[0].ndone, 5);
    chk("b2b_ndone_d2", u[1].ndone, 3);
    chk("b2b_ndone_d5", u[2].ndone, 1);
    chk("b2b_nframes_d2", u[1].nw, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b_word%0d_d2", k), int'(u[1].words[k]), (k % 2 == 0) ? 32'h3111 : 32'hB222);
    end
    chk("b2b_protocol_d2", u[1].viol, 0);
    chk("b2b_overrun_d1", int'(u[0].overrun), 1);
    chk("b2b_overrun_d5", int'(u[2].overrun), 1);

    // Reset in the middle of frame B (CLK_DIV=2)
    clr_mon();
    accept(12'h1A5, 12'h2B6);
    repeat (97) @(negedge clk);
    chk("abort_mid_frame_cs", int'(u[1].cs_n), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_pins_d2", int'(u[1].pins), int'(7'b1001000));
    chk("abort_pins_d5", int'(u[2].pins), int'(7'b1001000));
    chk("abort_overrun_cleared", int'(u[0].overrun), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (400) @(negedge clk);
    chk("abort_no_done_d2", u[1].ndone, 0);
    chk("abort_no_ldac_d2", u[1].nl, 0);
    chk("abort_no_done_d5", u[2].ndone, 0);
    chk("abort_no_ldac_d5", u[2].nl, 0);
    chk("abort_idle_d2", int'(u[1].pins), int'(7'b1001000));

    // Vector table; inputs are scrambled after accept to prove they were latched
    for (int i = 0; i < 4; i++) begin
      clr_mon();
      accept(vecs[i].a, vecs[i].b);
      u_dac_a = ~vecs[i].a;
      u_dac_b = ~vecs[i].b;
      repeat (40) @(negedge clk);
      u_dac_a = 12'($urandom);
      u_dac_b = 12'($urandom);
      repeat (330) @(negedge clk);
      chk_xfer($sformatf("v%0d_d1", i), 1, vecs[i].wa, vecs[i].wb, u[0].nw, u[0].words[0], u[0].words[1],
               u[0].rises[0], u[0].rises[1], u[0].nb, u[0].busy_lens[0], u[0].nl,
               u[0].ldac_lens[0], u[0].hmin, u[0].hmax, u[0].pmin, u[0].pmax, u[0].viol, u[0].ndone);
      chk_xfer($sformatf("v%0d_d2", i), 2, vecs[i].wa, vecs[i].wb, u[1].nw, u[1].words[0], u[1].words[1],
               u[1].rises[0], u[1].rises[1], u[1].nb, u[1].busy_lens[0], u[1].nl,
               u[1].ldac_lens[0], u[1].hmin, u[1].hmax, u[1].pmin, u[1].pmax, u[1].viol, u[1].ndone);
      chk_xfer($sformatf("v%0d_d5", i), 5, vecs[i].wa, vecs[i].wb, u[2].nw, u[2].words[0], u[2].words[1],
               u[2].rises[0], u[2].rises[1], u[2].nb, u[2].busy_lens[0], u[2].nl,
               u[2].ldac_lens[0], u[2].hmin, u[2].hmax, u[2].pmin, u[2].pmax, u[2].viol, u[2].ndone);
      chk($sformatf("v%0d_no_overrun", i), int'(u[1].overrun), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
